mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the pipelined datapath, between the ALU stage and the WB stage. Holds a 4-line direct-mapped write-back data cache (16-byte lines) and a miss FSM that talks to the memory controller over its data-side request/ack interface. It registers the ALU-to-WB pipeline values, returns load data, and asserts `block_pipe_data_cache` to stall the pipeline on a miss.

## Interface
- `LINES`, 4: cache lines, power of two; index = addr[5:4].
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `wrt_en` in 1: pipeline-register enable (EN_REG_MEM) from decode hazard logic.
- `alu_result` in 32: ALU result; byte address for loads/stores.
- `regBdata` in 32: store data.
- `regD` in 5: destination register.
- `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `MEM_TO_REG` in 1 each: control from ALU stage.
- `data_from_mem` in 128: fill line from mem_ctrl.
- `read_ready_for_dcache` in 1: one-cycle pulse, fill data valid.
- `written_data_ack` in 1: one-cycle pulse, write-back accepted.
- `alu_result_to_wb` out 32, `read_data_mem_to_wb` out 32, `regD_to_wb` out 5, `WB_EN_TO_WB` out 1, `MEM_TO_REG_TO_WB` out 1: registered outputs to WB.
- `block_pipe_data_cache` out 1: combinational stall request.
- `reqD_cache` out 1: memory request, level.
- `reqD_cache_write` out 1: 1 = write-back, 0 = fill.
- `reqAddrD_mem` out 26: fill line address, addr[29:4].
- `reqAddrD_write_mem` out 26: victim line address {tag, index}.
- `data_to_mem` out 128: victim line data.

## Operation
- Address split: word = addr[3:2], index = addr[5:4], tag = addr[29:6] (24 bits). addr[31:30] and addr[1:0] are ignored. Accesses are word-only.
- Per line: valid, dirty, tag, 128-bit data. Word w occupies data[32w+31:32w].
- access = MEM_R_EN | MEM_W_EN. hit = access & valid[idx] & tag match. If both enables are set, the access is a store and no load data is returned.
- FSM states: IDLE, WBACK, FILL.
- IDLE, no access or hit:
  - `block_pipe_data_cache` = 0.
  - If `wrt_en`, load the WB registers. A load returns the selected word. A store hit writes regBdata into the selected word and sets dirty.
  - Stores commit only when `wrt_en` = 1.
- IDLE, miss: `block_pipe_data_cache` = 1. Next state is WBACK if the victim is valid and dirty, otherwise FILL.
- WBACK:
  - Outputs: reqD_cache = 1, reqD_cache_write = 1, reqAddrD_write_mem = victim {tag, idx}, data_to_mem = victim data.
  - On written_data_ack: clear dirty, go to FILL.
- FILL:
  - Outputs: reqD_cache = 1, reqD_cache_write = 0, reqAddrD_mem = alu_result[29:4].
  - On read_ready_for_dcache: install data_from_mem, set valid = 1, dirty = 0, write the tag, go to IDLE.
  - The stalled access then hits and completes in IDLE.
- `block_pipe_data_cache` = 1 in WBACK and FILL.
- While blocked, the WB registers load a bubble: WB_EN_TO_WB = 0, MEM_TO_REG_TO_WB = 0. Other fields are don't-care.
- If `wrt_en` = 0 with no block, the WB registers hold their value.
- Request inputs (alu_result, enables) are stable while blocked, because upstream is stalled.

## Timing
- Reset (async, low):
  - All outputs 0.
  - State IDLE; all valid and dirty bits cleared; cache data not cleared.
  - An in-flight request is dropped immediately. A late ack after reset is ignored.
- Hit latency: 1 cycle, input to WB registers.
- Clean miss: detect in cycle 0 (block = 1). Request runs from cycle 1 until the read_ready cycle N. IDLE at N+1, hit completes at the edge ending N+1. Total N+2 cycles.
- Dirty miss adds the WBACK cycles. Write-back strictly precedes fill; no overlap.
- reqD_cache stays high continuously from entering WBACK until the fill completes. reqD_cache_write falls at the cycle after the write ack.
- Acks arriving in a state that does not expect them are ignored: read_ready outside FILL, written_data_ack outside WBACK.
- An ack arriving in the same cycle the request is first asserted is accepted.

## Test plan
- Reset, then load at 0x40: clean miss, block = 1 for 4 cycles with ack at request cycle 3. reqAddrD_mem = 0x000004. Fill 0xDDDD_CCCC_BBBB_AAAA_... gives read_data_mem_to_wb = word0, with a bubble to WB during the stall.
- Store 0x12345678 to 0x44 (hit after prior fill), then load 0x44: 1-cycle each, read returns 0x12345678, no memory request.
- Dirty eviction:
  - Load 0x84 (same index 0, tag differs): reqD_cache_write = 1 with reqAddrD_write_mem = 0x000004 and the line containing 0x12345678.
  - After written_data_ack, a fill of 0x000008 follows.
- Reset asserted mid-FILL: reqD_cache and block drop asynchronously. A subsequent read_ready pulse is ignored. The next load to 0x40 misses again.
- wrt_en = 0 during a store hit: cache line unchanged, WB registers hold. Spurious read_ready in IDLE: no state change.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: 4-line direct-mapped write-back data cache, miss FSM toward
// the memory controller, and the MEM-to-WB pipeline registers.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | serve hits; on a miss pick WBACK (dirty victim) or FILL
//   S_WBACK | victim line offered to memory, waiting for written_data_ack
//   S_FILL  | fill request outstanding, waiting for read_ready_for_dcache
module mem_stage #(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wrt_en,
  input  logic [31:0]  alu_result,
  input  logic [31:0]  regBdata,
  input  logic [4:0]   regD,
  input  logic         WB_EN,
  input  logic         MEM_R_EN,
  input  logic         MEM_W_EN,
  input  logic         MEM_TO_REG,
  input  logic [127:0] data_from_mem,
  input  logic         read_ready_for_dcache,
  input  logic         written_data_ack,
  output logic [31:0]  alu_result_to_wb,
  output logic [31:0]  read_data_mem_to_wb,
  output logic [4:0]   regD_to_wb,
  output logic         WB_EN_TO_WB,
  output logic         MEM_TO_REG_TO_WB,
  output logic         block_pipe_data_cache,
  output logic         reqD_cache,
  output logic         reqD_cache_write,
  output logic [25:0]  reqAddrD_mem,
  output logic [25:0]  reqAddrD_write_mem,
  output logic [127:0] data_to_mem
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 26 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WBACK, S_FILL} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       line_q [LINES];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag_in;
  logic [1:0]         word_sel;
  logic [6:0]         bit_base;
  logic               access;
  logic               is_load;
  logic               hit;
  logic               miss_idle;
  logic               blk_int;
  logic               store_commit;
  logic               fill_done;
  logic [31:0]        rd_word;
  logic               unused_addr_bits;

  assign idx       = alu_result[4 +: IDX_W];
  assign tag_in    = alu_result[29 -: TAG_W];
  assign word_sel  = alu_result[3:2];
  assign bit_base  = {word_sel, 5'b0};
  assign unused_addr_bits = ^{alu_result[31:30], alu_result[1:0]};

  assign access    = MEM_R_EN | MEM_W_EN;
  assign is_load   = MEM_R_EN & ~MEM_W_EN;
  assign hit       = access & valid_q[idx] & (tag_q[idx] == tag_in);
  assign miss_idle = (state_q == S_IDLE) & access & ~hit;
  assign blk_int   = (state_q != S_IDLE) | miss_idle;
  assign rd_word   = line_q[idx][bit_base +: 32];

  assign store_commit = (state_q == S_IDLE) & wrt_en & MEM_W_EN & hit;
  assign fill_done    = (state_q == S_FILL) & read_ready_for_dcache;

  // Gated by reset so the stall drops the moment reset is asserted.
  assign block_pipe_data_cache = reset & blk_int;

  // Line storage carries no reset; valid bits alone make it meaningful.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      line_q[idx] <= data_from_mem;
    end else if (store_commit) begin
      line_q[idx][bit_base +: 32] <= regBdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= S_IDLE;
      valid_q            <= '0;
      dirty_q            <= '0;
      reqD_cache         <= 1'b0;
      reqD_cache_write   <= 1'b0;
      reqAddrD_mem       <= '0;
      reqAddrD_write_mem <= '0;
      data_to_mem        <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (store_commit) begin
            dirty_q[idx] <= 1'b1;
          end
          if (miss_idle) begin
            reqD_cache   <= 1'b1;
            reqAddrD_mem <= alu_result[29:4];
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q            <= S_WBACK;
              reqD_cache_write   <= 1'b1;
              reqAddrD_write_mem <= {tag_q[idx], idx};
              data_to_mem        <= line_q[idx];
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_WBACK: begin
          if (written_data_ack) begin
            dirty_q[idx]     <= 1'b0;
            reqD_cache_write <= 1'b0;
            state_q          <= S_FILL;
          end
        end
        S_FILL: begin
          if (read_ready_for_dcache) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= tag_in;
            reqD_cache   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // WB registers: bubble while stalled, hold when not enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_to_wb    <= '0;
      read_data_mem_to_wb <= '0;
      regD_to_wb          <= '0;
      WB_EN_TO_WB         <= 1'b0;
      MEM_TO_REG_TO_WB    <= 1'b0;
    end else if (blk_int) begin
      WB_EN_TO_WB      <= 1'b0;
      MEM_TO_REG_TO_WB <= 1'b0;
    end else if (wrt_en) begin
      alu_result_to_wb    <= alu_result;
      read_data_mem_to_wb <= is_load ? rd_word : 32'h0;
      regD_to_wb          <= regD;
      WB_EN_TO_WB         <= WB_EN;
      MEM_TO_REG_TO_WB    <= MEM_TO_REG;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: fills, hits, dirty eviction, reset mid-fill,
// held WB registers and ignored stray acknowledges.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         wrt_en;
  logic [31:0]  alu_result;
  logic [31:0]  regBdata;
  logic [4:0]   regD;
  logic         WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG;
  logic [127:0] data_from_mem;
  logic         read_ready_for_dcache;
  logic         written_data_ack;
  logic [31:0]  alu_result_to_wb;
  logic [31:0]  read_data_mem_to_wb;
  logic [4:0]   regD_to_wb;
  logic         WB_EN_TO_WB, MEM_TO_REG_TO_WB;
  logic         block_pipe_data_cache;
  logic         reqD_cache, reqD_cache_write;
  logic [25:0]  reqAddrD_mem, reqAddrD_write_mem;
  logic [127:0] data_to_mem;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] F1    = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] F1_ST = 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA;
  localparam logic [127:0] F2    = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] FJUNK = {4{32'hFFFF_FFFF}};

  mem_stage #(.LINES(4)) dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en), .alu_result(alu_result),
    .regBdata(regBdata), .regD(regD), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .MEM_TO_REG(MEM_TO_REG), .data_from_mem(data_from_mem),
    .read_ready_for_dcache(read_ready_for_dcache), .written_data_ack(written_data_ack),
    .alu_result_to_wb(alu_result_to_wb), .read_data_mem_to_wb(read_data_mem_to_wb),
    .regD_to_wb(regD_to_wb), .WB_EN_TO_WB(WB_EN_TO_WB), .MEM_TO_REG_TO_WB(MEM_TO_REG_TO_WB),
    .block_pipe_data_cache(block_pipe_data_cache), .reqD_cache(reqD_cache),
    .reqD_cache_write(reqD_cache_write), .reqAddrD_mem(reqAddrD_mem),
    .reqAddrD_write_mem(reqAddrD_write_mem), .data_to_mem(data_to_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [4:0] rd, input logic wb,
                     input logic m2r);
    MEM_R_EN   = r;
    MEM_W_EN   = w;
    alu_result = a;
    regBdata   = d;
    regD       = rd;
    WB_EN      = wb;
    MEM_TO_REG = m2r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    wrt_en = 1'b0;
    drv(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    data_from_mem = '0;
    read_ready_for_dcache = 1'b0;
    written_data_ack = 1'b0;

    // Reset state
    go(); go();
    chk("rst_block", block_pipe_data_cache, 0);
    chk("rst_req", reqD_cache, 0);
    chk("rst_req_wr", reqD_cache_write, 0);
    chk("rst_wb_en", WB_EN_TO_WB, 0);
    chk("rst_alu_wb", alu_result_to_wb, 0);
    chk("rst_fill_addr", reqAddrD_mem, 0);
    reset = 1'b1;
    wrt_en = 1'b1;
    go();

    // Clean miss on load 0x40, ack in request cycle 3
    drv(1, 0, 32'h40, 32'h0, 5'd5, 1, 1);
    mid();
    chk("b_block_c0", block_pipe_data_cache, 1);
    chk("b_req_c0", reqD_cache, 0);
    go(); mid();
    chk("b_block_c1", block_pipe_data_cache, 1);
    chk("b_req_c1", reqD_cache, 1);
    chk("b_req_wr_c1", reqD_cache_write, 0);
    chk("b_fill_addr", reqAddrD_mem, 26'h000004);
    chk("b_bubble_wb", WB_EN_TO_WB, 0);
    chk("b_bubble_m2r", MEM_TO_REG_TO_WB, 0);
    go(); mid();
    chk("b_block_c2", block_pipe_data_cache, 1);
    go();
    data_from_mem = F1;
    read_ready_for_dcache = 1'b1;
    mid();
    chk("b_block_c3", block_pipe_data_cache, 1);
    chk("b_req_c3", reqD_cache, 1);
    go();
    read_ready_for_dcache = 1'b0;
    mid();
    chk("b_block_c4", block_pipe_data_cache, 0);
    chk("b_req_c4", reqD_cache, 0);
    go();
    chk("b_rdata", read_data_mem_to_wb, 32'hAAAAAAAA);
    chk("b_wb_en", WB_EN_TO_WB, 1);
    chk("b_m2r", MEM_TO_REG_TO_WB, 1);
    chk("b_regd", regD_to_wb, 5'd5);
    chk("b_alu", alu_result_to_wb, 32'h40);

    // Store hit 0x44, then load hit 0x44
    drv(0, 1, 32'h44, 32'h12345678, 5'd0, 0, 0);
    mid();
    chk("c_st_block", block_pipe_data_cache, 0);
    go();
    chk("c_st_wb_en", WB_EN_TO_WB, 0);
    drv(1, 0, 32'h44, 32'h0, 5'd7, 1, 1);
    mid();
    chk("c_ld_block", block_pipe_data_cache, 0);
    chk("c_ld_req", reqD_cache, 0);
    go();
    chk("c_ld_rdata", read_data_mem_to_wb, 32'h12345678);
    chk("c_ld_regd", regD_to_wb, 5'd7);

    // Store hit with wrt_en low plus stray write ack: nothing changes
    wrt_en = 1'b0;
    written_data_ack = 1'b1;
    drv(0, 1, 32'h44, 32'hDEADBEEF, 5'd3, 0, 0);
    mid();
    chk("d_block", block_pipe_data_cache, 0);
    go();
    written_data_ack = 1'b0;
    chk("d_hold_regd", regD_to_wb, 5'd7);
    chk("d_hold_rdata", read_data_mem_to_wb, 32'h12345678);
    chk("d_hold_wb_en", WB_EN_TO_WB, 1);
    chk("d_hold_alu", alu_result_to_wb, 32'h44);
    wrt_en = 1'b1;
    // Stray read_ready in IDLE during a hit
    drv(1, 0, 32'h44, 32'h0, 5'd8, 1, 1);
    data_from_mem = FJUNK;
    read_ready_for_dcache = 1'b1;
    mid();
    chk("d_spur_block", block_pipe_data_cache, 0);
    chk("d_spur_req", reqD_cache, 0);
    go();
    read_ready_for_dcache = 1'b0;
    chk("d_unchanged_44", read_data_mem_to_wb, 32'h12345678);
    drv(1, 0, 32'h40, 32'h0, 5'd8, 1, 1);
    mid();
    chk("d_block_40", block_pipe_data_cache, 0);
    go();
    chk("d_unchanged_40", read_data_mem_to_wb, 32'hAAAAAAAA);

    // Dirty eviction: load 0x84, ack arrives in first request cycle
    drv(1, 0, 32'h84, 32'h0, 5'd9, 1, 1);
    mid();
    chk("e_block_c0", block_pipe_data_cache, 1);
    chk("e_req_c0", reqD_cache, 0);
    go(); mid();
    chk("e_req_c1", reqD_cache, 1);
    chk("e_req_wr_c1", reqD_cache_write, 1);
    chk("e_victim_addr", reqAddrD_write_mem, 26'h000004);
    chk("e_victim_data", data_to_mem, F1_ST);
    chk("e_block_c1", block_pipe_data_cache, 1);
    written_data_ack = 1'b1;
    go();
    written_data_ack = 1'b0;
    mid();
    chk("e_req_c2", reqD_cache, 1);
    chk("e_req_wr_c2", reqD_cache_write, 0);
    chk("e_fill_addr", reqAddrD_mem, 26'h000008);
    chk("e_block_c2", block_pipe_data_cache, 1);
    data_from_mem = F2;
    read_ready_for_dcache = 1'b1;
    go();
    read_ready_for_dcache = 1'b0;
    mid();
    chk("e_block_c3", block_pipe_data_cache, 0);
    chk("e_req_c3", reqD_cache, 0);
    go();
    chk("e_rdata", read_data_mem_to_wb, 32'h22222222);
    chk("e_regd", regD_to_wb, 5'd9);

    // Reload 0x44: victim now clean, straight to fill
    drv(1, 0, 32'h44, 32'h0, 5'd11, 1, 1);
    mid();
    chk("f_block_c0", block_pipe_data_cache, 1);
    go(); mid();
    chk("f_req_c1", reqD_cache, 1);
    chk("f_req_wr_c1", reqD_cache_write, 0);
    chk("f_fill_addr", reqAddrD_mem, 26'h000004);
    data_from_mem = F1_ST;
    read_ready_for_dcache = 1'b1;
    go();
    read_ready_for_dcache = 1'b0;
    mid();
    chk("f_block_c2", block_pipe_data_cache, 0);
    go();
    chk("f_rdata", read_data_mem_to_wb, 32'h12345678);

    // Reset asserted mid-fill
    drv(1, 0, 32'h84, 32'h0, 5'd10, 1, 1);
    mid();
    chk("g_block_c0", block_pipe_data_cache, 1);
    go(); mid();
    chk("g_req_c1", reqD_cache, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("g_req_async", reqD_cache, 0);
    chk("g_block_async", block_pipe_data_cache, 0);
    chk("g_wb_en_async", WB_EN_TO_WB, 0);
    go();
    drv(0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    reset = 1'b1;
    data_from_mem = FJUNK;
    read_ready_for_dcache = 1'b1;
    mid();
    chk("g_late_block", block_pipe_data_cache, 0);
    go();
    read_ready_for_dcache = 1'b0;
    mid();
    chk("g_late_req", reqD_cache, 0);
    chk("g_late_block2", block_pipe_data_cache, 0);
    go();
    drv(1, 0, 32'h40, 32'h0, 5'd12, 1, 1);
    mid();
    chk("g_miss_again", block_pipe_data_cache, 1);
    go(); mid();
    chk("g_req_again", reqD_cache, 1);
    chk("g_fill_addr_again", reqAddrD_mem, 26'h000004);
    data_from_mem = F1;
    read_ready_for_dcache = 1'b1;
    go();
    read_ready_for_dcache = 1'b0;
    mid();
    chk("g_block_done", block_pipe_data_cache, 0);
    go();
    chk("g_rdata", read_data_mem_to_wb, 32'hAAAAAAAA);
    chk("g_regd", regD_to_wb, 5'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
